// File: rtl/pulse_xy_meter_pkg.sv
// Shared FSM state type and default sizing for the two-axis pulse meter.
package pulse_xy_meter_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StArmed,
    StRunning
  } axis_state_e;

  localparam int unsigned DefCntW    = 16;
  localparam int unsigned DefPerW    = 24;
  localparam int unsigned DefTimeout = 5000000;

endpackage

// File: rtl/pulse_axis_meter.sv
// Single-axis pulse meter: synchroniser, rising-edge counter, edge-to-edge period timer
// and stall detection.
module pulse_axis_meter
  import pulse_xy_meter_pkg::*;
#(
  parameter int unsigned CNT_W   = DefCntW,
  parameter int unsigned PER_W   = DefPerW,
  parameter int unsigned TIMEOUT = DefTimeout
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pulse,
  input  logic             clr,
  output logic [CNT_W-1:0] count,
  output logic [PER_W-1:0] period,
  output logic             valid,
  output logic             stall,
  output logic             ovf
);

  localparam logic [PER_W-1:0] TimeoutVal = PER_W'(TIMEOUT);
  localparam logic [PER_W-1:0] TimerOne   = PER_W'(1);
  localparam logic [CNT_W-1:0] CntOne     = CNT_W'(1);

  axis_state_e      state_q, state_d;
  logic [PER_W-1:0] timer_q, timer_d;
  logic [PER_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             valid_q, valid_d;
  logic             stall_q, stall_d;
  logic             ovf_q, ovf_d;
  logic             meta_q, sync_q, prev_q;
  logic             edge_det;

  assign edge_det = sync_q & ~prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= pulse;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    period_d = period_q;
    valid_d  = 1'b0;
    stall_d  = stall_q;
    unique case (state_q)
      StIdle: begin
        if (edge_det) begin
          state_d = StArmed;
          timer_d = TimerOne;
          stall_d = 1'b0;
        end
      end
      StArmed, StRunning: begin
        // An edge landing on the timeout cycle still wins over the stall.
        if (edge_det) begin
          state_d  = StRunning;
          period_d = timer_q;
          valid_d  = 1'b1;
          timer_d  = TimerOne;
        end else if (timer_q >= TimeoutVal) begin
          state_d  = StIdle;
          period_d = '0;
          stall_d  = 1'b1;
          timer_d  = '0;
        end else begin
          timer_d = timer_q + TimerOne;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    count_d = count_q;
    ovf_d   = ovf_q;
    if (clr) begin
      count_d = edge_det ? CntOne : '0;
      ovf_d   = 1'b0;
    end else if (edge_det) begin
      count_d = count_q + CntOne;
      if (&count_q) begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      timer_q  <= '0;
      period_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      stall_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      period_q <= period_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      stall_q  <= stall_d;
      ovf_q    <= ovf_d;
    end
  end

  assign count  = count_q;
  assign period = period_q;
  assign valid  = valid_q;
  assign stall  = stall_q;
  assign ovf    = ovf_q;

endmodule

// File: rtl/pulse_xy_meter.sv
// Two-axis receive-side monitor for Pulse_X/Pulse_Y: one independent meter per axis.
module pulse_xy_meter
  import pulse_xy_meter_pkg::*;
#(
  parameter int unsigned CNT_W   = DefCntW,
  parameter int unsigned PER_W   = DefPerW,
  parameter int unsigned TIMEOUT = DefTimeout
) (
  input  logic             sysclk,
  input  logic             reset,
  input  logic             Pulse_X,
  input  logic             Pulse_Y,
  input  logic             Clr,
  output logic [CNT_W-1:0] Count_X,
  output logic [CNT_W-1:0] Count_Y,
  output logic [PER_W-1:0] Period_X,
  output logic [PER_W-1:0] Period_Y,
  output logic             Valid_X,
  output logic             Valid_Y,
  output logic             Stall_X,
  output logic             Stall_Y,
  output logic             Ovf_X,
  output logic             Ovf_Y
);

  pulse_axis_meter #(
    .CNT_W  (CNT_W),
    .PER_W  (PER_W),
    .TIMEOUT(TIMEOUT)
  ) u_axis_x (
    .clk   (sysclk),
    .rst   (reset),
    .pulse (Pulse_X),
    .clr   (Clr),
    .count (Count_X),
    .period(Period_X),
    .valid (Valid_X),
    .stall (Stall_X),
    .ovf   (Ovf_X)
  );

  pulse_axis_meter #(
    .CNT_W  (CNT_W),
    .PER_W  (PER_W),
    .TIMEOUT(TIMEOUT)
  ) u_axis_y (
    .clk   (sysclk),
    .rst   (reset),
    .pulse (Pulse_Y),
    .clr   (Clr),
    .count (Count_Y),
    .period(Period_Y),
    .valid (Valid_Y),
    .stall (Stall_Y),
    .ovf   (Ovf_Y)
  );

endmodule

// File: doc/pulse_xy_meter.md
# pulse_xy_meter

Receive-side monitor for the two-axis pulse outputs (Pulse_X, Pulse_Y) produced by Main_F3. It synchronises each pulse line into the sysclk domain and counts rising edges per axis. It also measures the edge-to-edge period in sysclk cycles and flags a stalled axis, so a bench or on-board checker can confirm the generated step rate and step count.

## Interface
- CNT_W, 16: width of per-axis edge counters.
- PER_W, 24: width of per-axis period registers and timers.
- TIMEOUT, 5000000: cycles without an edge before an axis is declared stalled (100 ms at 50 MHz).
- sysclk  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-high reset.
- Pulse_X  in  1  X pulse line, asynchronous to sysclk.
- Pulse_Y  in  1  Y pulse line, asynchronous to sysclk.
- Clr  in  1  synchronous clear of counts and overflow flags, single-cycle.
- Count_X, Count_Y  out  CNT_W  rising-edge count per axis.
- Period_X, Period_Y  out  PER_W  last measured edge-to-edge period in cycles; 0 when not measured.
- Valid_X, Valid_Y  out  1  one-cycle strobe when Period_* is updated.
- Stall_X, Stall_Y  out  1  axis timed out; held until the next edge.
- Ovf_X, Ovf_Y  out  1  sticky count wrap flag.

## Operation
- Reset values: all counts, periods and timers are 0. Valid, Stall and Ovf are 0. Each axis is in IDLE.
- Each axis has a 2-flop synchroniser followed by a registered previous-sample flop. An edge is detected when sync2=1 and prev=0.
- Per-axis FSM:
  - IDLE: no reference edge yet. On an edge: go to ARMED, timer <= 1, Count += 1, Stall <= 0.
  - ARMED: timer increments each cycle, saturating at TIMEOUT.
    - On an edge: Period <= timer, Valid pulses, timer <= 1, go to RUNNING.
    - If timer reaches TIMEOUT first: go to IDLE, Stall <= 1, Period <= 0.
  - RUNNING: same as ARMED. Each edge updates Period and pulses Valid. A timeout returns to IDLE with Stall <= 1 and Period <= 0.
- Period semantics: edges every N cycles give Period = N. N=1 cannot occur because of the edge detector, so the minimum is 2.
- Count wraps from 2^CNT_W-1 to 0 and sets Ovf, which stays set until Clr or reset.
- Clr zeros Count and Ovf only; FSM state, Period and Stall are unaffected. If Clr and an edge occur in the same cycle, Count = 1.
- An edge at exactly the same cycle timer hits TIMEOUT counts as an edge, not a stall.
- The X and Y axes are fully independent; simultaneous edges on both are handled in parallel.
- Reset asserted mid-measurement returns everything to reset values immediately, with no Valid strobe.

## Timing
- Latency: an input rise first sampled at sysclk edge k updates Count, Period and Valid at edge k+2.
- A pulse high or low for less than one sysclk period may be missed. Input pulses must be at least 2 cycles high and 2 cycles low.
- Valid is exactly one cycle wide. Stall asserts on the cycle after timer reaches TIMEOUT.

## Structure
- The shared package holds the FSM state enum (IDLE, ARMED, RUNNING) and the default CNT_W, PER_W and TIMEOUT constants.
- Sub-module pulse_axis_meter contains the synchroniser, FSM, counter and timer. It is instantiated twice (X and Y). The top level is wiring only.

## Test plan
- Reset release, inputs low for 1000 cycles: all outputs 0, both FSMs in IDLE.
- Pulse_X square wave with 10-cycle period, 5 edges: Count_X=5. Period_X=10 after the 2nd edge, with 4 Valid_X strobes. Y outputs remain 0.
- X period 8 and Y period 12 run concurrently: Period_X=8, Period_Y=12, and counts are independent.
- TIMEOUT overridden to 100, one edge then silence: Stall_X rises 101 cycles after the edge and Period_X=0. The next edge clears Stall_X and increments Count_X, with no Valid strobe on that edge.
- CNT_W=4, 17 edges: Count_X=1 and Ovf_X=1. A Clr then gives Count_X=0 and Ovf_X=0. Clr coincident with an edge gives Count_X=1.
- Reset asserted mid-train: outputs 0 within the same cycle. After release, the first edge gives Count=1 and Period stays 0 until the second edge.
